// File: rtl/front_panel_ctl.sv
// Front-panel conditioner for the teaching CPU: synchronises and debounces buttons and
// DIP switches, makes press pulses, divides the clock and runs the HALTED/RUN/STEP FSM.
module front_panel_ctl #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int TICK_DIV        = 2097152
) (
    input  logic       CLK_12MHz,
    input  logic       RST_N,
    input  logic [5:0] Switch,
    input  logic [7:0] DPSwitch,
    input  logic       halt_req,
    output logic [5:0] btn_level,
    output logic [5:0] btn_press,
    output logic [7:0] dp_level,
    output logic       cpu_tick,
    output logic       core_reset,
    output logic       running,
    output logic [1:0] view_sel
);

    localparam int NIN = 14;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW  = $clog2(TICK_DIV);
    // Buttons idle high (released), DIP switches idle low.
    localparam logic [NIN-1:0] SYNC_RST = {8'h00, 6'h3F};

    typedef enum logic [1:0] {ST_HALTED, ST_RUN, ST_STEP} state_t;

    logic [NIN-1:0] sync1, sync2;
    logic [NIN-1:0] sampled;
    logic [NIN-1:0] level;
    logic [NIN-1:0] flip;
    logic [CW-1:0]  cnt [NIN];
    logic [DW-1:0]  div_cnt;
    logic           div_hit;
    state_t         state, state_nxt;
    logic           tick_nxt, core_reset_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_12MHz or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
        end else begin
            sync1 <= {DPSwitch, Switch};
            sync2 <= sync1;
        end
    end

    assign sampled = {sync2[13:6], ~sync2[5:0]};

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        flip = '0;
        for (int i = 0; i < NIN; i++) begin
            flip[i] = (sampled[i] != level[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES));
        end
    end

    // NOTE: the counters are ordinary flops, not a RAM, so they can and do take the async reset.
    always_ff @(posedge CLK_12MHz or negedge RST_N) begin
        if (!RST_N) begin
            level     <= '0;
            btn_press <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            level     <= level ^ flip;
            btn_press <= flip[5:0] & ~level[5:0];
            for (int i = 0; i < NIN; i++) begin
                if (sampled[i] == level[i] || flip[i]) cnt[i] <= '0;
                else                                   cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    assign btn_level = level[5:0];
    assign dp_level  = level[13:6];

    assign div_hit = (div_cnt == DW'(TICK_DIV - 1));

    always_ff @(posedge CLK_12MHz or negedge RST_N) begin
        if (!RST_N) div_cnt <= '0;
        else        div_cnt <= div_hit ? '0 : div_cnt + DW'(1);
    end

    always_comb begin
        state_nxt      = state;
        tick_nxt       = 1'b0;
        core_reset_nxt = 1'b0;
        if (btn_press[1]) begin
            state_nxt      = ST_HALTED;
            core_reset_nxt = 1'b1;
        end else begin
            case (state)
                ST_HALTED: if (btn_press[0]) state_nxt = dp_level[7] ? ST_STEP : ST_RUN;
                ST_STEP: begin
                    tick_nxt  = 1'b1;
                    state_nxt = ST_HALTED;
                end
                ST_RUN: begin
                    // A halt or pause request wins over a coincident divider hit.
                    if (halt_req || btn_press[0]) state_nxt = ST_HALTED;
                    else                          tick_nxt  = div_hit;
                end
                default: state_nxt = ST_HALTED;
            endcase
        end
    end

    always_ff @(posedge CLK_12MHz or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_HALTED;
            cpu_tick   <= 1'b0;
            core_reset <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_tick   <= tick_nxt;
            core_reset <= core_reset_nxt;
            running    <= (state_nxt == ST_RUN);
        end
    end

    always_ff @(posedge CLK_12MHz or negedge RST_N) begin
        if (!RST_N)            view_sel <= 2'd0;
        else if (btn_press[2]) view_sel <= 2'd0;
        else if (btn_press[3]) view_sel <= 2'd1;
        else if (btn_press[4]) view_sel <= 2'd2;
        else if (btn_press[5]) view_sel <= 2'd3;
    end

endmodule
